mem_rd_lat_chk: RTL

Multi-port read-latency checker and statistics block for memory wrappers with NUMPRT packed read ports. It delays each port's read request and address through a LATENCY-deep pipeline and checks that `read_vld` returns exactly LATENCY cycles later. It flags missing and spurious responses, captures the address of the first failing read, and keeps saturating per-port read, single-error and double-error counts. It sits beside the memory wrapper in the verification and bring-up fabric and connects to the packed read-port signal set.

---
 rtl/mem_chk_pkg.sv | 16 +
 rtl/mem_rd_lat_chk_if.sv | 35 +++
 rtl/mem_dly_pipe.sv | 31 +++
 rtl/mem_rd_lat_chk.sv | 118 +++++++++++
 4 files changed

// File: rtl/mem_chk_pkg.sv
// Shared constants and helpers for the memory read-latency checker.
package mem_chk_pkg;

  localparam int unsigned MAX_LATENCY = 30;
  localparam int unsigned BLANK_W     = $clog2(MAX_LATENCY + 1);
  localparam int unsigned SAT_W       = 32;

  // Increment val, holding at the all-ones value of a width-bit counter (width <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input int unsigned       width);
    logic [SAT_W-1:0] max_val;
    max_val = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    return (val >= max_val) ? max_val : val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/mem_rd_lat_chk_if.sv
// Packed multi-port read signal set seen by the latency checker.
interface mem_rd_lat_chk_if #(
  parameter int unsigned AW     = 8,
  parameter int unsigned NUMPRT = 1,
  parameter int unsigned CW     = 16
);

  logic [NUMPRT-1:0]    read;
  logic [NUMPRT*AW-1:0] addr;
  logic [NUMPRT-1:0]    read_vld;
  logic [NUMPRT-1:0]    read_serr;
  logic [NUMPRT-1:0]    read_derr;

  logic [NUMPRT-1:0]    read_d;
  logic [NUMPRT*AW-1:0] addr_d;
  logic [NUMPRT-1:0]    miss_err;
  logic [NUMPRT-1:0]    spur_err;
  logic [NUMPRT*AW-1:0] err_addr;
  logic [NUMPRT*CW-1:0] rd_cnt;
  logic [NUMPRT*CW-1:0] serr_cnt;
  logic [NUMPRT*CW-1:0] derr_cnt;

  // Memory wrapper / stimulus side.
  modport master (
    output read, addr, read_vld, read_serr, read_derr,
    input  read_d, addr_d, miss_err, spur_err, err_addr, rd_cnt, serr_cnt, derr_cnt
  );

  // Checker side.
  modport slave (
    input  read, addr, read_vld, read_serr, read_derr,
    output read_d, addr_d, miss_err, spur_err, err_addr, rd_cnt, serr_cnt, derr_cnt
  );

endinterface

// File: rtl/mem_dly_pipe.sv
// Generic DEPTH-stage delay line with synchronous reset; wire when DEPTH is 0.
module mem_dly_pipe #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] stg [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) stg[i] <= '0;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < int'(DEPTH); i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/mem_rd_lat_chk.sv
// Per-port read-latency checker: delays requests, flags missing/spurious
// responses, captures the first failing address and keeps saturating counts.
module mem_rd_lat_chk
  import mem_chk_pkg::*;
#(
  parameter int unsigned AW      = 8,
  parameter int unsigned NUMPRT  = 1,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  mem_rd_lat_chk_if.slave      bus
);

  localparam int unsigned PW = AW + 1;

  logic [BLANK_W-1:0]   blank;
  logic                 spur_en;

  logic [NUMPRT-1:0]    read_d_w;
  logic [NUMPRT*AW-1:0] addr_d_w;
  logic [NUMPRT-1:0]    miss_err_w;
  logic [NUMPRT-1:0]    spur_err_w;
  logic [NUMPRT*AW-1:0] err_addr_w;
  logic [NUMPRT*CW-1:0] rd_cnt_w;
  logic [NUMPRT*CW-1:0] serr_cnt_w;
  logic [NUMPRT*CW-1:0] derr_cnt_w;

  // Responses to reads issued before reset may still land for LATENCY cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank <= BLANK_W'(LATENCY);
    end else if (blank != '0) begin
      blank <= blank - BLANK_W'(1);
    end
  end

  assign spur_en = (blank == '0);

  for (genvar i = 0; i < NUMPRT; i++) begin : g_port
    logic [PW-1:0] pipe_in;
    logic [PW-1:0] pipe_out;
    logic          rd_d;
    logic [AW-1:0] ad_d;
    logic          vld;
    logic          miss;
    logic          spur;
    logic          hit;

    logic          miss_q;
    logic          spur_q;
    logic [AW-1:0] err_addr_q;
    logic [CW-1:0] rd_q;
    logic [CW-1:0] serr_q;
    logic [CW-1:0] derr_q;

    assign pipe_in = {bus.read[i], bus.addr[i*AW +: AW]};

    mem_dly_pipe #(
      .W     (PW),
      .DEPTH (LATENCY)
    ) u_pipe (
      .clk (clk),
      .rst (rst),
      .d   (pipe_in),
      .q   (pipe_out)
    );

    assign rd_d = pipe_out[AW];
    assign ad_d = pipe_out[AW-1:0];
    assign vld  = bus.read_vld[i];
    assign miss = rd_d & ~vld;
    assign spur = ~rd_d & vld & spur_en;
    assign hit  = rd_d & vld;

    // clr outranks any same-cycle event; the delay pipe keeps running.
    always_ff @(posedge clk) begin
      if (rst || clr) begin
        miss_q     <= 1'b0;
        spur_q     <= 1'b0;
        err_addr_q <= '0;
        rd_q       <= '0;
        serr_q     <= '0;
        derr_q     <= '0;
      end else begin
        if (miss) begin
          miss_q <= 1'b1;
          if (!miss_q) err_addr_q <= ad_d;
        end
        if (spur) spur_q <= 1'b1;
        if (bus.read[i]) rd_q <= CW'(sat_inc(SAT_W'(rd_q), CW));
        if (hit && bus.read_serr[i]) serr_q <= CW'(sat_inc(SAT_W'(serr_q), CW));
        if (hit && bus.read_derr[i]) derr_q <= CW'(sat_inc(SAT_W'(derr_q), CW));
      end
    end

    assign read_d_w[i]             = rd_d;
    assign addr_d_w[i*AW +: AW]    = ad_d;
    assign miss_err_w[i]           = miss_q;
    assign spur_err_w[i]           = spur_q;
    assign err_addr_w[i*AW +: AW]  = err_addr_q;
    assign rd_cnt_w[i*CW +: CW]    = rd_q;
    assign serr_cnt_w[i*CW +: CW]  = serr_q;
    assign derr_cnt_w[i*CW +: CW]  = derr_q;
  end

  assign bus.read_d   = read_d_w;
  assign bus.addr_d   = addr_d_w;
  assign bus.miss_err = miss_err_w;
  assign bus.spur_err = spur_err_w;
  assign bus.err_addr = err_addr_w;
  assign bus.rd_cnt   = rd_cnt_w;
  assign bus.serr_cnt = serr_cnt_w;
  assign bus.derr_cnt = derr_cnt_w;

endmodule
